// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Purpose  : 4-entry ALU reservation station with CDB wakeup and a single
//            registered issue port. Optional macro ALU_RS_AGE_ORDER_EN selects
//            oldest-ready issue via an age matrix; otherwise lowest-index-ready.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs #(
   parameter int DATA_W   = 32,
   parameter int TAG_W    = 4,
   parameter int OP_W     = 5,
   parameter int TAG_FREE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   in_op,
   input  logic [TAG_W-1:0]  in_tag1,
   input  logic [TAG_W-1:0]  in_tag2,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [DATA_W-1:0] in_data2,
   input  logic [TAG_W-1:0]  in_dest,
   output logic              full,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              flush,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [OP_W-1:0]   issue_op,
   output logic [DATA_W-1:0] issue_data1,
   output logic [DATA_W-1:0] issue_data2,
   output logic [TAG_W-1:0]  issue_dest
);

   localparam int                N    = 4;
   localparam logic [TAG_W-1:0]  FREE = TAG_W'(TAG_FREE);

   logic [N-1:0]      ent_v;
   logic [OP_W-1:0]   ent_op   [N];
   logic [TAG_W-1:0]  ent_t1   [N];
   logic [TAG_W-1:0]  ent_t2   [N];
   logic [TAG_W-1:0]  ent_dest [N];
   logic [DATA_W-1:0] ent_d1   [N];
   logic [DATA_W-1:0] ent_d2   [N];

   logic [N-1:0] rdy;
   logic [N-1:0] grant;
   logic [N-1:0] alloc_oh;
   logic [1:0]   sel_idx;
   logic         load;
   logic         issue_fire;
   logic         alloc_en;
   logic         fwd1;
   logic         fwd2;

   assign full       = &ent_v;
   assign load       = !issue_valid || issue_ready;
   assign issue_fire = load && (|grant);
   assign alloc_en   = in_valid && !full && !flush;
   assign fwd1       = cdb_valid && (in_tag1 == cdb_tag) && (in_tag1 != FREE);
   assign fwd2       = cdb_valid && (in_tag2 == cdb_tag) && (in_tag2 != FREE);

   always_comb begin
      rdy      = '0;
      alloc_oh = '0;
      for (int i = N - 1; i >= 0; i--) begin
         rdy[i] = ent_v[i] && (ent_t1[i] == FREE) && (ent_t2[i] == FREE);
         if (!ent_v[i]) begin
            alloc_oh    = '0;
            alloc_oh[i] = 1'b1;
         end
      end
   end

`ifdef ALU_RS_AGE_ORDER_EN
   // older[i][j] set means entry j was allocated before entry i
   logic [N-1:0] older [N];

   always_comb begin
      grant = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = rdy[i] && ((rdy & older[i]) == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) older[i] <= '0;
      end else if (alloc_en) begin
         for (int i = 0; i < N; i++) begin
            if (alloc_oh[i]) older[i] <= ent_v;
            else             older[i] <= older[i] & ~alloc_oh;
         end
      end
   end
`else
   always_comb begin
      grant = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rdy[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) sel_idx = 2'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         ent_v <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (alloc_en && alloc_oh[i]) begin
               ent_v[i]    <= 1'b1;
               ent_op[i]   <= in_op;
               ent_dest[i] <= in_dest;
               ent_t1[i]   <= fwd1 ? FREE : in_tag1;
               ent_d1[i]   <= fwd1 ? cdb_data : in_data1;
               ent_t2[i]   <= fwd2 ? FREE : in_tag2;
               ent_d2[i]   <= fwd2 ? cdb_data : in_data2;
            end else begin
               if (issue_fire && grant[i]) ent_v[i] <= 1'b0;
               if (cdb_valid && ent_v[i] && ent_t1[i] == cdb_tag && ent_t1[i] != FREE) begin
                  ent_t1[i] <= FREE;
                  ent_d1[i] <= cdb_data;
               end
               if (cdb_valid && ent_v[i] && ent_t2[i] == cdb_tag && ent_t2[i] != FREE) begin
                  ent_t2[i] <= FREE;
                  ent_d2[i] <= cdb_data;
               end
            end
         end
      end
   end

   // Data fields keep their last value whenever nothing new is loaded
   always_ff @(posedge clk) begin
      if (!rst) begin
         issue_valid <= 1'b0;
         issue_op    <= '0;
         issue_data1 <= '0;
         issue_data2 <= '0;
         issue_dest  <= '0;
      end else if (flush) begin
         issue_valid <= 1'b0;
      end else if (load) begin
         issue_valid <= |grant;
         if (|grant) begin
            issue_op    <= ent_op[sel_idx];
            issue_data1 <= ent_d1[sel_idx];
            issue_data2 <= ent_d2[sel_idx];
            issue_dest  <= ent_dest[sel_idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs
// Purpose  : Self-checking bench for alu_rs: directed scenarios plus random
//            traffic compared every cycle against a slot/age-stamp model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_rs;
   localparam int DW = 32;
   localparam int TW = 4;
   localparam int OW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [OW-1:0] in_op = '0;
   logic [TW-1:0] in_tag1 = '0, in_tag2 = '0, in_dest = '0;
   logic [DW-1:0] in_data1 = '0, in_data2 = '0;
   logic          full;
   logic          cdb_valid = 1'b0;
   logic [TW-1:0] cdb_tag = '0;
   logic [DW-1:0] cdb_data = '0;
   logic          flush = 1'b0;
   logic          issue_valid;
   logic          issue_ready = 1'b0;
   logic [OW-1:0] issue_op;
   logic [DW-1:0] issue_data1, issue_data2;
   logic [TW-1:0] issue_dest;

   always #5 clk = ~clk;

   alu_rs #(.DATA_W(DW), .TAG_W(TW), .OP_W(OW), .TAG_FREE(0)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_op(in_op),
      .in_tag1(in_tag1), .in_tag2(in_tag2),
      .in_data1(in_data1), .in_data2(in_data2),
      .in_dest(in_dest), .full(full),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_op(issue_op), .issue_data1(issue_data1),
      .issue_data2(issue_data2), .issue_dest(issue_dest)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: four slots, allocation order kept as a global stamp
   typedef struct {
      bit            v;
      logic [OW-1:0] op;
      logic [TW-1:0] t1, t2, dest;
      logic [DW-1:0] d1, d2;
      int unsigned   age;
   } slot_t;

   slot_t         m [4];
   bit            m_iv = 1'b0;
   logic [OW-1:0] m_op = '0;
   logic [TW-1:0] m_dest = '0;
   logic [DW-1:0] m_d1 = '0, m_d2 = '0;
   int unsigned   stamp = 0;
   bit            cmp_en = 1'b0;

   function automatic bit m_full();
      bit f = 1'b1;
      for (int i = 0; i < 4; i++) f &= m[i].v;
      return f;
   endfunction

   always @(posedge clk) begin : model
      int sel;
      int fr;
      bit fn;
      if (!rst) begin
         for (int i = 0; i < 4; i++) m[i].v = 1'b0;
         m_iv = 1'b0; m_op = '0; m_dest = '0; m_d1 = '0; m_d2 = '0;
      end else if (flush) begin
         for (int i = 0; i < 4; i++) m[i].v = 1'b0;
         m_iv = 1'b0;
      end else begin
         fn  = m_full();
         sel = -1;
         fr  = -1;
         for (int i = 3; i >= 0; i--) if (!m[i].v) fr = i;
         if (!m_iv || issue_ready) begin
            for (int i = 0; i < 4; i++) begin
               if (m[i].v && m[i].t1 == 0 && m[i].t2 == 0) begin
`ifdef ALU_RS_AGE_ORDER_EN
                  if (sel < 0 || m[i].age < m[sel].age) sel = i;
`else
                  if (sel < 0) sel = i;
`endif
               end
            end
            m_iv = (sel >= 0);
            if (sel >= 0) begin
               m_op = m[sel].op; m_d1 = m[sel].d1; m_d2 = m[sel].d2; m_dest = m[sel].dest;
               m[sel].v = 1'b0;
            end
         end
         if (cdb_valid) begin
            for (int i = 0; i < 4; i++) begin
               if (m[i].v && m[i].t1 == cdb_tag && cdb_tag != 0) begin m[i].t1 = 0; m[i].d1 = cdb_data; end
               if (m[i].v && m[i].t2 == cdb_tag && cdb_tag != 0) begin m[i].t2 = 0; m[i].d2 = cdb_data; end
            end
         end
         if (in_valid && !fn) begin
            stamp++;
            m[fr].v    = 1'b1;
            m[fr].op   = in_op;
            m[fr].dest = in_dest;
            m[fr].age  = stamp;
            m[fr].t1   = (cdb_valid && in_tag1 == cdb_tag && in_tag1 != 0) ? '0 : in_tag1;
            m[fr].d1   = (cdb_valid && in_tag1 == cdb_tag && in_tag1 != 0) ? cdb_data : in_data1;
            m[fr].t2   = (cdb_valid && in_tag2 == cdb_tag && in_tag2 != 0) ? '0 : in_tag2;
            m[fr].d2   = (cdb_valid && in_tag2 == cdb_tag && in_tag2 != 0) ? cdb_data : in_data2;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_full",        full,        m_full());
         chk("cyc_issue_valid", issue_valid, m_iv);
         chk("cyc_issue_op",    issue_op,    m_op);
         chk("cyc_issue_data1", issue_data1, m_d1);
         chk("cyc_issue_data2", issue_data2, m_d2);
         chk("cyc_issue_dest",  issue_dest,  m_dest);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      in_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic dispatch(input logic [OW-1:0] op, input logic [TW-1:0] t1, input logic [DW-1:0] d1,
                           input logic [TW-1:0] t2, input logic [DW-1:0] d2, input logic [TW-1:0] dest);
      in_valid = 1'b1; in_op = op; in_tag1 = t1; in_data1 = d1;
      in_tag2 = t2; in_data2 = d2; in_dest = dest;
   endtask

   task automatic bcast(input logic [TW-1:0] t, input logic [DW-1:0] d);
      cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
   endtask

   initial begin
      logic [TW-1:0] got [$];
      logic [TW-1:0] exp_order [3];

      rst = 1'b0; idle(); issue_ready = 1'b0;
      tick(); tick();
      cmp_en = 1'b1;
      chk("reset_full", full, 0);
      chk("reset_issue_valid", issue_valid, 0);
      chk("reset_issue_dest", issue_dest, 0);
      chk("reset_issue_data1", issue_data1, 0);
      rst = 1'b1;

      // Minimum latency: both operands free
      issue_ready = 1'b1;
      dispatch(5'd0, 4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
      tick(); idle();
      chk("lat_edge1_valid", issue_valid, 0);
      tick();
      chk("lat_edge2_valid", issue_valid, 1);
      chk("lat_data1", issue_data1, 5);
      chk("lat_data2", issue_data2, 7);
      chk("lat_dest", issue_dest, 3);
      chk("lat_model_data1", m_d1, 5);
      tick();
      chk("lat_drained", issue_valid, 0);

      // Wakeup from CDB three cycles after dispatch
      dispatch(5'd1, 4'd6, 32'h1, 4'd0, 32'h2, 4'd4);
      tick(); idle(); tick(); tick();
      bcast(4'd6, 32'h10);
      tick(); idle();
      chk("wake_edge1_valid", issue_valid, 0);
      tick();
      chk("wake_edge2_valid", issue_valid, 1);
      chk("wake_data1", issue_data1, 32'h10);
      chk("wake_data2", issue_data2, 32'h2);
      tick();

      // Same-cycle forwarding on dispatch
      dispatch(5'd2, 4'd0, 32'h3, 4'd9, 32'h0, 4'd5);
      bcast(4'd9, 32'hAA);
      tick(); idle();
      chk("fwd_edge1_valid", issue_valid, 0);
      tick();
      chk("fwd_valid", issue_valid, 1);
      chk("fwd_data2", issue_data2, 32'hAA);
      chk("fwd_data1", issue_data1, 32'h3);
      tick();

      // Fill, drop a fifth dispatch, then release all four
      for (int k = 0; k < 4; k++) begin
         dispatch(5'd3, 4'd2, 32'd0, 4'd0, 32'd0, 4'(8 + k));
         tick();
      end
      idle();
      chk("fill_full", full, 1);
      dispatch(5'd3, 4'd0, 32'd0, 4'd0, 32'd0, 4'd12);
      tick(); idle();
      chk("drop_full", full, 1);
      chk("drop_no_issue", issue_valid, 0);
      bcast(4'd2, 32'h22);
      tick(); idle();
      got.delete();
      for (int k = 0; k < 8; k++) begin
         tick();
         if (issue_valid) begin
            got.push_back(issue_dest);
            chk("fill_issue_data1", issue_data1, 32'h22);
         end
      end
      chk("fill_issue_count", got.size(), 4);
      for (int k = 0; k < got.size() && k < 4; k++) chk("fill_issue_dest", got[k], 8 + k);
      chk("fill_empty_after", full, 0);

      // Stalled issue holds, then flush
      issue_ready = 1'b0;
      dispatch(5'd4, 4'd0, 32'd1, 4'd0, 32'd1, 4'd1); tick();
      dispatch(5'd4, 4'd0, 32'd2, 4'd0, 32'd2, 4'd2); tick();
      dispatch(5'd4, 4'd0, 32'd3, 4'd0, 32'd3, 4'd3); tick();
      idle();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_valid", issue_valid, 1);
         chk("stall_dest", issue_dest, 1);
         chk("stall_data1", issue_data1, 1);
         chk("stall_full", full, 0);
      end
      flush = 1'b1;
      tick(); idle();
      chk("flush_valid", issue_valid, 0);
      chk("flush_full", full, 0);
      issue_ready = 1'b1;
      tick(); tick();
      chk("flush_entries_gone", issue_valid, 0);

      // Reset while an issue is stalled overrides dispatch, CDB and flush
      issue_ready = 1'b0;
      dispatch(5'd5, 4'd0, 32'd9, 4'd0, 32'd9, 4'd7);
      tick(); idle(); tick();
      chk("rst_stall_valid", issue_valid, 1);
      chk("rst_stall_dest", issue_dest, 7);
      rst = 1'b0;
      dispatch(5'd5, 4'd0, 32'd4, 4'd0, 32'd4, 4'd6);
      bcast(4'd3, 32'h5);
      flush = 1'b1;
      tick();
      rst = 1'b1; idle();
      chk("rst_mid_valid", issue_valid, 0);
      chk("rst_mid_dest", issue_dest, 0);
      chk("rst_mid_data1", issue_data1, 0);
      chk("rst_mid_full", full, 0);
      issue_ready = 1'b1;
      tick(); tick();
      chk("rst_mid_no_issue", issue_valid, 0);

      // Issue ordering: entry 2 allocated before entries 0 and 1 are refilled
      dispatch(5'd6, 4'd5, 32'd0, 4'd0, 32'd0, 4'd10); tick();
      dispatch(5'd6, 4'd6, 32'd0, 4'd0, 32'd0, 4'd11); tick();
      dispatch(5'd6, 4'd7, 32'd0, 4'd0, 32'd0, 4'd2);  tick();
      idle();
      bcast(4'd5, 32'h1); tick();
      bcast(4'd6, 32'h2); tick();
      idle(); tick(); tick();
      dispatch(5'd6, 4'd7, 32'd0, 4'd0, 32'd0, 4'd0); tick();
      dispatch(5'd6, 4'd7, 32'd0, 4'd0, 32'd0, 4'd1); tick();
      idle();
      bcast(4'd7, 32'h77); tick();
      idle();
      got.delete();
      for (int k = 0; k < 5; k++) begin
         tick();
         if (issue_valid) got.push_back(issue_dest);
      end
`ifdef ALU_RS_AGE_ORDER_EN
      exp_order[0] = 4'd2; exp_order[1] = 4'd0; exp_order[2] = 4'd1;
`else
      exp_order[0] = 4'd0; exp_order[1] = 4'd1; exp_order[2] = 4'd2;
`endif
      chk("order_count", got.size(), 3);
      for (int k = 0; k < 3 && k < got.size(); k++) chk("order_dest", got[k], exp_order[k]);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 199) != 0);
         flush       = ($urandom_range(0, 59) == 0);
         issue_ready = ($urandom_range(0, 3) != 0);
         in_valid    = ($urandom_range(0, 1) == 1);
         in_op       = OW'($urandom);
         in_tag1     = ($urandom_range(0, 1) == 1) ? 4'd0 : TW'($urandom_range(1, 7));
         in_tag2     = ($urandom_range(0, 1) == 1) ? 4'd0 : TW'($urandom_range(1, 7));
         in_data1    = $urandom;
         in_data2    = $urandom;
         in_dest     = TW'($urandom);
         cdb_valid   = ($urandom_range(0, 2) != 0);
         cdb_tag     = TW'($urandom_range(0, 7));
         cdb_data    = $urandom;
         tick();
      end
      rst = 1'b1; idle();
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL expose parameters, one per line: name, default, meaning:
- DATA_W, 32, operand width.
- TAG_W, 4, ROB tag width.
- OP_W, 5, ALU opcode width.
- TAG_FREE, 0, tag value meaning "operand holds a value".
REQ-002 SHALL expose ports, one per line: name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-low reset.
- in_valid, in, 1, dispatch request from decoder.
- in_op, in, OP_W, ALU opcode.
- in_tag1 / in_tag2, in, TAG_W, source tags.
- in_data1 / in_data2, in, DATA_W, source values.
- in_dest, in, TAG_W, destination ROB tag.
- full, out, 1, no free entry.
- cdb_valid, in, 1, result broadcast.
- cdb_tag, in, TAG_W, broadcast tag.
- cdb_data, in, DATA_W, broadcast value.
- flush, in, 1, discard all entries.
- issue_valid, out, 1, ALU request.
- issue_ready, in, 1, ALU accepts.
- issue_op, out, OP_W, issued opcode.
- issue_data1 / issue_data2, out, DATA_W, issued operands.
- issue_dest, out, TAG_W, issued destination tag.

Function
REQ-003 SHALL hold 4 entries, each with: valid, op, tag1, data1, tag2, data2, dest.
REQ-004 full SHALL be combinational: high iff all 4 entries are valid, evaluated on current state.
REQ-005 in_valid && !full && !flush SHALL allocate the lowest-index free entry at the clock edge.
REQ-006 in_valid while full SHALL be dropped with no state change; a same-cycle issue does not create room for it.
REQ-007 On allocation, if cdb_valid and in_tagN == cdb_tag and in_tagN != TAG_FREE, the entry SHALL store tagN = TAG_FREE and dataN = cdb_data; otherwise it stores the inputs unchanged.
REQ-008 Every cycle with cdb_valid, each valid entry operand whose tag equals cdb_tag (and is not TAG_FREE) SHALL capture cdb_data and set its tag to TAG_FREE at the edge.
REQ-009 An entry SHALL be ready iff it is valid and tag1 == tag2 == TAG_FREE, judged on registered state. An operand woken in cycle k is therefore eligible in cycle k+1.
REQ-010 The issue register SHALL load when !issue_valid || issue_ready. Load behaviour:
- If a ready entry exists, copy it to the issue outputs, set issue_valid = 1, and free that entry at the same edge.
- Otherwise set issue_valid = 0.
REQ-011 While issue_valid && !issue_ready, all issue outputs SHALL hold stable and no entry SHALL be freed.
REQ-012 Minimum latency SHALL be 2 edges: allocate at edge N with both operands free, issue_valid high after edge N+1.
REQ-013 An entry being freed by issue SHALL NOT be reallocated at the same edge.
REQ-014 flush SHALL take priority over allocation, wakeup and issue. At the edge it clears all entry valids and issue_valid.
REQ-015 Issue output data fields SHALL retain their last values when issue_valid = 0.

Reset
REQ-016 rst == 0 at a rising edge SHALL clear:
- all entry valids and the age state;
- issue_valid, issue_op, issue_data1, issue_data2 and issue_dest, all to 0.
REQ-017 Reset SHALL override flush, dispatch and CDB. It takes effect mid-operation, including while an issue is stalled.
REQ-018 After reset, full = 0.

Configuration
REQ-019 Macro ALU_RS_AGE_ORDER_EN:
- Defined: a 4x4 age matrix SHALL be maintained. On allocation, the new entry is marked younger than every currently valid entry. Selection picks the ready entry with no older ready entry.
- Undefined: selection SHALL pick the lowest-index ready entry, and no age state exists.
- All other behaviour is identical in both builds.

Verification
REQ-020 Reset, then dispatch op=ADD, tag1=tag2=0, data1=5, data2=7, dest=3, with issue_ready=1 -> issue_valid high 2 edges later with data1=5, data2=7, dest=3.
REQ-021 Dispatch tag1=6, then 3 cycles later drive cdb_valid with tag=6, data=0x10 -> issue_valid rises on the 2nd edge after the broadcast, with issue_data1=0x10.
REQ-022 Dispatch tag2=9 in the same cycle as a CDB broadcast of tag=9, data=0xAA -> the entry is ready immediately and issues with issue_data2=0xAA.
REQ-023 Fill 4 entries, all waiting on tag 2, then drive in_valid on a 5th -> full=1, the 5th is dropped. Broadcast tag 2 -> exactly 4 issues follow.
REQ-024 Hold issue_ready=0 with 2 ready entries for 5 cycles -> outputs stable, no entry freed. Assert flush -> issue_valid=0 and full=0 next cycle.
REQ-025 With ALU_RS_AGE_ORDER_EN defined, dispatch into entry 2, then into entries 0 and 1 after entry 0 was freed, all ready -> issue order is 2, 0, 1. With the macro undefined -> issue order is 0, 1, 2.
